// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI RX message assembler.
package mipi_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2
  } state_e;

  localparam logic [47:0] HDR_DEFAULT = 48'hA0B0C0A0B0C0;

  // Beats needed to cover a message; the final beat may be partially used.
  function automatic int nwords_f(input int dlen, input int word_w);
    return (dlen + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/sat_cnt16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_cnt16 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_q <= '0;
    else if (en && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mipi_rx_assembler.sv
// Assembles HDR-framed MIPI RX beats on one locked virtual channel into a
// DLEN-bit message held until the consumer accepts it.
module mipi_rx_assembler
  import mipi_rx_pkg::*;
#(
  parameter int                DLEN   = 512,
  parameter int                WORD_W = 48,
  parameter int                NUM_VC = 4,
  parameter logic [WORD_W-1:0] HDR    = WORD_W'(HDR_DEFAULT)
) (
  input  logic              rx_pixel_clk,
  input  logic              rst,
  input  logic              rx_valid,
  input  logic [63:0]       rx_data,
  input  logic [1:0]        rx_vc,
  input  logic [17:0]       rx_error,
  input  logic [NUM_VC-1:0] vc_ena,
  output logic [DLEN-1:0]   data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic [1:0]        data_vc,
  output logic              busy,
  output logic [15:0]       frame_cnt,
  output logic [15:0]       err_cnt,
  output logic [15:0]       drop_cnt
);

  localparam int NWORDS = nwords_f(DLEN, WORD_W);
  localparam int CW     = $clog2(NWORDS + 1);
  localparam logic [CW-1:0] LAST = CW'(NWORDS - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] wcnt_q, wcnt_d;
  logic [1:0]    vc_q, vc_d;
  logic          store, err_inc, frame_inc, drop_inc;
  logic [3:0]    ena4;
  logic          qual, is_hdr, has_err;

  // Channels beyond NUM_VC read as disabled.
  always_comb begin
    ena4 = '0;
    for (int i = 0; i < NUM_VC; i++) ena4[i] = vc_ena[i];
  end

  assign qual    = rx_valid && ena4[rx_vc];
  assign is_hdr  = (rx_data[WORD_W-1:0] == HDR);
  assign has_err = rx_valid && (rx_error != '0);

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    vc_d      = vc_q;
    store     = 1'b0;
    err_inc   = 1'b0;
    frame_inc = 1'b0;
    drop_inc  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (qual && is_hdr) begin
          vc_d    = rx_vc;
          wcnt_d  = '0;
          state_d = ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (has_err) begin
          err_inc = 1'b1;
          state_d = ST_IDLE;
        end else if (qual && rx_vc == vc_q) begin
          if (is_hdr) begin
            err_inc = 1'b1;
            wcnt_d  = '0;
          end else begin
            store = 1'b1;
            if (wcnt_q == LAST) state_d = ST_HOLD;
            else                wcnt_d  = wcnt_q + CW'(1);
          end
        end
      end
      ST_HOLD: begin
        if (data_ready) begin
          frame_inc = 1'b1;
          // A header arriving on the hand-off cycle starts the next message.
          if (qual && is_hdr) begin
            vc_d    = rx_vc;
            wcnt_d  = '0;
            state_d = ST_COLLECT;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (qual) begin
          drop_inc = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_pixel_clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      vc_q    <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      vc_q    <= vc_d;
    end
  end

  // One register per beat slot; the last slot keeps only the bits that fit.
  for (genvar w = 0; w < NWORDS; w++) begin : g_word
    localparam int LO = w * WORD_W;
    localparam int WB = (DLEN - LO < WORD_W) ? (DLEN - LO) : WORD_W;
    logic [WB-1:0] word_q;
    always_ff @(posedge rx_pixel_clk or posedge rst) begin
      if (rst)                               word_q <= '0;
      else if (store && wcnt_q == CW'(w))    word_q <= rx_data[WB-1:0];
    end
    assign data[LO +: WB] = word_q;
  end

  assign data_valid = (state_q == ST_HOLD);
  assign busy       = (state_q != ST_IDLE);
  assign data_vc    = vc_q;

  sat_cnt16 u_frame (.clk(rx_pixel_clk), .rst(rst), .en(frame_inc), .cnt(frame_cnt));
  sat_cnt16 u_err   (.clk(rx_pixel_clk), .rst(rst), .en(err_inc),   .cnt(err_cnt));
  sat_cnt16 u_drop  (.clk(rx_pixel_clk), .rst(rst), .en(drop_inc),  .cnt(drop_cnt));

endmodule

// File: tb/tb_mipi_rx_assembler.sv
// Directed bench for mipi_rx_assembler at default parameters.
module tb_mipi_rx_assembler;

  localparam logic [63:0] HDRW = 64'h0000A0B0C0A0B0C0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         rx_valid = 1'b0;
  logic [63:0]  rx_data = '0;
  logic [1:0]   rx_vc = '0;
  logic [17:0]  rx_error = '0;
  logic [3:0]   vc_ena = 4'b0001;
  logic [511:0] data;
  logic         data_valid;
  logic         data_ready = 1'b0;
  logic [1:0]   data_vc;
  logic         busy;
  logic [15:0]  frame_cnt, err_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;
  logic [511:0] held;

  mipi_rx_assembler dut (
    .rx_pixel_clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_vc(rx_vc), .rx_error(rx_error), .vc_ena(vc_ena), .data(data),
    .data_valid(data_valid), .data_ready(data_ready), .data_vc(data_vc),
    .busy(busy), .frame_cnt(frame_cnt), .err_cnt(err_cnt), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat for one clock, sample 1ns after the edge.
  task automatic send(input logic [63:0] d, input logic [1:0] vc, input logic [17:0] err);
    rx_valid = 1'b1; rx_data = d; rx_vc = vc; rx_error = err;
    @(posedge clk); #1;
    rx_valid = 1'b0; rx_error = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #3;
    chk("rst_valid", 64'(data_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_data", data[63:0], 0);
    chk("rst_frame", 64'(frame_cnt), 0);
    chk("rst_err", 64'(err_cnt), 0);
    chk("rst_drop", 64'(drop_cnt), 0);
    @(posedge clk); #1; rst = 1'b0;
    tick(1);

    // Basic message on VC0
    send(HDRW, 2'd0, '0);
    chk("t1_busy", 64'(busy), 1);
    for (int i = 1; i <= 10; i++) send(64'(i), 2'd0, '0);
    chk("t1_dv_early", 64'(data_valid), 0);
    send(64'd11, 2'd0, '0);
    chk("t1_dv", 64'(data_valid), 1);
    chk("t1_w0", 64'(data[47:0]), 64'h1);
    chk("t1_w1", 64'(data[95:48]), 64'h2);
    chk("t1_top", 64'(data[511:480]), 64'h0000000B);
    chk("t1_vc", 64'(data_vc), 0);
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    chk("t1_frame", 64'(frame_cnt), 1);
    chk("t1_dv_done", 64'(data_valid), 0);
    chk("t1_idle", 64'(busy), 0);

    // Error abort
    send(HDRW, 2'd0, '0);
    for (int i = 1; i <= 4; i++) send(64'(i + 32), 2'd0, '0);
    send(64'h55, 2'd0, 18'h00001);
    chk("t2_busy", 64'(busy), 0);
    chk("t2_err", 64'(err_cnt), 1);
    chk("t2_dv", 64'(data_valid), 0);
    chk("t2_frame", 64'(frame_cnt), 1);

    // Back-pressure in HOLD, then hand-off with header in the same cycle
    send(HDRW, 2'd0, '0);
    for (int i = 1; i <= 11; i++) send(64'(i + 256), 2'd0, '0);
    chk("t3_dv", 64'(data_valid), 1);
    held = data;
    for (int i = 0; i < 5; i++) send(64'hDEAD, 2'd0, '0);
    tick(15);
    chk("t3_hold_w0", 64'(data[47:0]), 64'h101);
    chk("t3_hold_same", 64'(data !== held), 0);
    chk("t3_drop", 64'(drop_cnt), 5);
    chk("t3_dv_hold", 64'(data_valid), 1);
    data_ready = 1'b1;
    send(HDRW, 2'd0, '0);
    data_ready = 1'b0;
    chk("t3_frame", 64'(frame_cnt), 2);
    chk("t3_collect", 64'(busy), 1);
    chk("t3_dv_off", 64'(data_valid), 0);
    send(64'h1, 2'd0, 18'h00002);
    chk("t3_abort_err", 64'(err_cnt), 2);

    // VC filtering
    vc_ena = 4'b0010;
    send(HDRW, 2'd0, '0);
    chk("t4_vc0_hdr_ignored", 64'(busy), 0);
    send(HDRW, 2'd1, '0);
    chk("t4_vc1_hdr", 64'(busy), 1);
    for (int i = 1; i <= 11; i++) begin
      send(64'(i + 3840), 2'd0, '0);
      send(64'(i * 16), 2'd1, '0);
    end
    chk("t4_dv", 64'(data_valid), 1);
    chk("t4_vc", 64'(data_vc), 1);
    chk("t4_w0", 64'(data[47:0]), 64'h10);
    chk("t4_w1", 64'(data[95:48]), 64'h20);
    chk("t4_top", 64'(data[511:480]), 64'h000000B0);
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    chk("t4_frame", 64'(frame_cnt), 3);

    // Header restart inside a message
    send(HDRW, 2'd1, '0);
    send(64'hA1, 2'd1, '0);
    send(64'hA2, 2'd1, '0);
    send(HDRW, 2'd1, '0);
    chk("t5_restart_err", 64'(err_cnt), 3);
    chk("t5_restart_busy", 64'(busy), 1);
    for (int i = 1; i <= 10; i++) send(64'(i + 176), 2'd1, '0);
    chk("t5_dv_early", 64'(data_valid), 0);
    send(64'hBB, 2'd1, '0);
    chk("t5_dv", 64'(data_valid), 1);
    chk("t5_w0", 64'(data[47:0]), 64'hB1);
    data_ready = 1'b1; tick(1); data_ready = 1'b0;
    chk("t5_frame", 64'(frame_cnt), 4);

    // Saturation of err_cnt
    force dut.u_err.cnt_q = 16'hFFFE;
    #1;
    release dut.u_err.cnt_q;
    chk("t6_forced", 64'(err_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      send(HDRW, 2'd1, '0);
      send(64'h7, 2'd1, 18'h00100);
    end
    chk("t6_sat", 64'(err_cnt), 64'hFFFF);

    // Asynchronous reset mid-collect
    send(HDRW, 2'd1, '0);
    for (int i = 1; i <= 3; i++) send(64'(i + 4096), 2'd1, '0);
    chk("t7_pre_busy", 64'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("t7_busy", 64'(busy), 0);
    chk("t7_dv", 64'(data_valid), 0);
    chk("t7_data", data[63:0], 0);
    chk("t7_data_top", 64'(data[511:480]), 0);
    chk("t7_vc", 64'(data_vc), 0);
    chk("t7_frame", 64'(frame_cnt), 0);
    chk("t7_err", 64'(err_cnt), 0);
    chk("t7_drop", 64'(drop_cnt), 0);
    @(posedge clk); #1; rst = 1'b0;
    tick(1);
    chk("t7_after_busy", 64'(busy), 0);
    chk("t7_after_err", 64'(err_cnt), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
